// File: rtl/npc_sprite_engine_if.sv
// npc_sprite_engine_if
//   Bundles the sprite engine's per-frame NPC inputs, scan position and
//   pixel-path results.
//   master : producer side (motion controller + VGA timing); drives the inputs
//            and reads the results.
//   slave  : the sprite engine.
//   Signals: frame_clk, DrawX/DrawY (scan position), Enemy_X/Y,
//            Enemy_Size_X/Y, Enemy_state (NPC motion outputs),
//            npc_on, rom_addr, anim_frame (engine results).
interface npc_sprite_engine_if #(
  parameter int ADDR_W = 17
);
  logic              frame_clk;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [9:0]        Enemy_X;
  logic [9:0]        Enemy_Y;
  logic [9:0]        Enemy_Size_X;
  logic [9:0]        Enemy_Size_Y;
  logic [9:0]        Enemy_state;
  logic              npc_on;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        anim_frame;

  modport master (
    output frame_clk, DrawX, DrawY, Enemy_X, Enemy_Y,
           Enemy_Size_X, Enemy_Size_Y, Enemy_state,
    input  npc_on, rom_addr, anim_frame
  );

  modport slave (
    input  frame_clk, DrawX, DrawY, Enemy_X, Enemy_Y,
           Enemy_Size_X, Enemy_Size_Y, Enemy_state,
    output npc_on, rom_addr, anim_frame
  );
endinterface

// File: rtl/npc_sprite_engine.sv
// npc_sprite_engine
//   Snapshots the NPC box once per video frame, sequences the NPC animation
//   frames, and maps the VGA scan position to a hit flag plus sprite-ROM
//   address through a two-stage pipeline.
//   Ports: Clk, Reset (async, active low), bus (npc_sprite_engine_if.slave).
//   npc_on/rom_addr follow DrawX/DrawY by 2 Clk cycles; anim_frame is
//   updated the cycle after a frame_clk rising edge.
module npc_sprite_engine #(
  parameter int SPR_W     = 64,
  parameter int SPR_H     = 160,
  parameter int FRAME_DIV = 6,
  parameter int ADDR_W    = 17
) (
  input logic                 Clk,
  input logic                 Reset,
  npc_sprite_engine_if.slave  bus
);
  localparam int DXW      = $clog2(SPR_W);
  localparam int DYW      = $clog2(SPR_H);
  localparam int FRAME_SZ = SPR_W * SPR_H;

  typedef enum logic [1:0] {
    SET_IDLE = 2'd0,
    SET_MOVE = 2'd1,
    SET_STOP = 2'd2
  } anim_set_t;

  // frame edge detect
  logic fe_prev, fe;
  assign fe = bus.frame_clk & ~fe_prev;

  // frame shadows: the pixel path only ever sees these
  logic [9:0] sx, sy, ssx, ssy;

  // animation sequencer
  anim_set_t  cur_set, new_set;
  logic [3:0] anim_frame, div, first_frame, next_frame;

  always_comb begin
    case (bus.Enemy_state)
      10'd1:   new_set = SET_MOVE;
      10'd2:   new_set = SET_STOP;
      default: new_set = SET_IDLE;
    endcase
  end

  always_comb begin
    case (new_set)
      SET_MOVE: first_frame = 4'd4;
      SET_STOP: first_frame = 4'd8;
      default:  first_frame = 4'd0;
    endcase
  end

  always_comb begin
    case (cur_set)
      SET_MOVE: next_frame = (anim_frame == 4'd7) ? 4'd4 : anim_frame + 4'd1;
      SET_STOP: next_frame = 4'd8;
      default:  next_frame = (anim_frame == 4'd3) ? 4'd0 : anim_frame + 4'd1;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fe_prev    <= 1'b0;
      sx         <= '0;
      sy         <= '0;
      ssx        <= '0;
      ssy        <= '0;
      cur_set    <= SET_IDLE;
      anim_frame <= '0;
      div        <= '0;
    end else begin
      fe_prev <= bus.frame_clk;
      if (fe) begin
        sx  <= bus.Enemy_X;
        sy  <= bus.Enemy_Y;
        ssx <= bus.Enemy_Size_X;
        ssy <= bus.Enemy_Size_Y;
        // a set change restarts the sequence and beats a divider tick
        if (new_set != cur_set) begin
          cur_set    <= new_set;
          anim_frame <= first_frame;
          div        <= '0;
        end else if (div == 4'(FRAME_DIV - 1)) begin
          div        <= '0;
          anim_frame <= next_frame;
        end else begin
          div <= div + 4'd1;
        end
      end
    end
  end

  // pixel stage 1: box test. 11-bit unsigned, so a Y wrapped below 0 is
  // simply a huge coordinate and never hits.
  logic [10:0]      dx, dy;
  logic             hit_c;
  logic             hit1;
  logic [DXW-1:0]   dx1;
  logic [DYW-1:0]   dy1;
  logic [3:0]       af1;

  assign dx    = {1'b0, bus.DrawX} - {1'b0, sx};
  assign dy    = {1'b0, bus.DrawY} - {1'b0, sy};
  assign hit_c = (bus.DrawX >= sx) & (bus.DrawY >= sy) &
                 (dx < {1'b0, ssx}) & (dy < {1'b0, ssy}) &
                 (dx < 11'(SPR_W)) & (dy < 11'(SPR_H));

  // pixel stage 2: ROM address. anim_frame is carried with the pixel so a
  // frame edge cannot change the frame of a pixel already in flight.
  logic [ADDR_W-1:0] addr_c;
  assign addr_c = ADDR_W'(af1) * ADDR_W'(FRAME_SZ) +
                  (ADDR_W'(dy1) << DXW) + ADDR_W'(dx1);

  logic              npc_on_q;
  logic [ADDR_W-1:0] rom_addr_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hit1       <= 1'b0;
      dx1        <= '0;
      dy1        <= '0;
      af1        <= '0;
      npc_on_q   <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      hit1       <= hit_c;
      dx1        <= dx[DXW-1:0];
      dy1        <= dy[DYW-1:0];
      af1        <= anim_frame;
      npc_on_q   <= hit1;
      rom_addr_q <= hit1 ? addr_c : '0;
    end
  end

  assign bus.npc_on     = npc_on_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.anim_frame = anim_frame;
endmodule

// File: tb/tb_npc_sprite_engine.sv
// tb_npc_sprite_engine
//   Directed bench for npc_sprite_engine with hand-computed expectations.
module tb_npc_sprite_engine;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  npc_sprite_engine_if #(.ADDR_W(17)) bus ();

  npc_sprite_engine #(
    .SPR_W(64), .SPR_H(160), .FRAME_DIV(6), .ADDR_W(17)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic fe_pulse();
    @(negedge Clk) bus.frame_clk = 1'b1;
    @(negedge Clk) bus.frame_clk = 1'b0;
  endtask

  task automatic fe_n(input int n);
    repeat (n) fe_pulse();
  endtask

  task automatic set_enemy(input logic [9:0] x, y, szx, szy, st);
    bus.Enemy_X = x; bus.Enemy_Y = y;
    bus.Enemy_Size_X = szx; bus.Enemy_Size_Y = szy;
    bus.Enemy_state = st;
  endtask

  // present one pixel and check the result 2 cycles later
  task automatic pix(input logic [9:0] x, y, input logic exp_on,
                     input logic [31:0] exp_addr, input string tag);
    @(negedge Clk);
    bus.DrawX = x; bus.DrawY = y;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk({tag, "_on"}, 32'(bus.npc_on), 32'(exp_on));
    chk({tag, "_addr"}, 32'(bus.rom_addr), exp_addr);
  endtask

  // back-to-back scan along one axis; counts cycles with npc_on or a
  // nonzero address
  task automatic sweep(input bit horiz, input logic [9:0] fixed, input int n,
                       output int hits);
    hits = 0;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge Clk);
      if (i >= 2 && (bus.npc_on || bus.rom_addr != '0)) hits++;
      if (i < n) begin
        if (horiz) begin bus.DrawX = 10'(i); bus.DrawY = fixed; end
        else       begin bus.DrawX = fixed;  bus.DrawY = 10'(i); end
      end
    end
  endtask

  int hits;

  initial begin
    Reset = 1'b0;
    bus.frame_clk = 1'b0;
    bus.DrawX = '0; bus.DrawY = '0;
    set_enemy(10'd324, 10'd110, 10'd63, 10'd160, 10'd0);
    repeat (3) @(negedge Clk);
    chk("rst_on", 32'(bus.npc_on), 32'd0);
    chk("rst_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_anim", 32'(bus.anim_frame), 32'd0);
    Reset = 1'b1;

    // no frame edge yet: shadow sizes are zero
    sweep(1'b1, 10'd110, 640, hits);
    chk("noedge_hits", 32'(hits), 32'd0);
    chk("noedge_anim", 32'(bus.anim_frame), 32'd0);

    // first edge (idle edge 1)
    fe_pulse();
    chk("idle_e1", 32'(bus.anim_frame), 32'd0);
    pix(10'd324, 10'd110, 1'b1, 32'd0,     "corner_tl");
    pix(10'd386, 10'd269, 1'b1, 32'd10238, "corner_br");
    pix(10'd387, 10'd110, 1'b0, 32'd0,     "right_out");
    pix(10'd323, 10'd110, 1'b0, 32'd0,     "left_out");
    pix(10'd324, 10'd270, 1'b0, 32'd0,     "below_out");

    // idle loop: frame steps every 6th edge, 3 wraps to 0
    for (int k = 2; k <= 24; k++) begin
      fe_pulse();
      chk($sformatf("idle_e%0d", k), 32'(bus.anim_frame), 32'((k / 6) % 4));
    end
    fe_n(12);
    chk("idle_f2", 32'(bus.anim_frame), 32'd2);

    // switch to MOVE: jumps to 4 with divider cleared
    bus.Enemy_state = 10'd1;
    fe_pulse();
    chk("move_first", 32'(bus.anim_frame), 32'd4);
    fe_n(5);
    chk("move_5", 32'(bus.anim_frame), 32'd4);
    fe_pulse();
    chk("move_6", 32'(bus.anim_frame), 32'd5);
    pix(10'd325, 10'd111, 1'b1, 32'd51265, "move_pix");

    // STOP holds 8; unknown state falls back to IDLE
    bus.Enemy_state = 10'd2;
    fe_pulse();
    chk("stop_first", 32'(bus.anim_frame), 32'd8);
    fe_n(30);
    chk("stop_hold", 32'(bus.anim_frame), 32'd8);
    bus.Enemy_state = 10'd7;
    fe_pulse();
    chk("state7_idle", 32'(bus.anim_frame), 32'd0);

    // wrapped Y never hits
    bus.Enemy_Y = 10'd1016;
    fe_pulse();
    sweep(1'b0, 10'd330, 480, hits);
    chk("wrapY_hits", 32'(hits), 32'd0);

    // moving X without an edge leaves the shadow box in place
    bus.Enemy_Y = 10'd110;
    fe_pulse();
    pix(10'd324, 10'd110, 1'b1, 32'd0, "restore");
    bus.Enemy_X = 10'd0;
    pix(10'd324, 10'd110, 1'b1, 32'd0, "nofe_old");
    pix(10'd0,   10'd110, 1'b0, 32'd0, "nofe_new");
    fe_pulse();
    pix(10'd1,   10'd111, 1'b1, 32'd65, "fe_new");
    pix(10'd324, 10'd110, 1'b0, 32'd0,  "fe_old");

    // mid-frame reset clears outputs at once; shadows need a fresh edge
    @(negedge Clk);
    bus.DrawX = 10'd1; bus.DrawY = 10'd111;
    repeat (3) @(negedge Clk);
    chk("prerst_on", 32'(bus.npc_on), 32'd1);
    Reset = 1'b0;
    #1;
    chk("midrst_on", 32'(bus.npc_on), 32'd0);
    chk("midrst_addr", 32'(bus.rom_addr), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    pix(10'd1, 10'd111, 1'b0, 32'd0, "postrst");
    fe_pulse();
    pix(10'd1, 10'd111, 1'b1, 32'd65, "postrst_fe");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
